// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: DEPTH-stage valid/ready pipeline register with an optional
// input skid entry. Empty stages fill during a stall, so bubbles collapse.
module pipe_stage_elastic #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1,
  parameter int SKID       = 1,
  localparam int OCC_W     = $clog2(DEPTH + SKID + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [OCC_W-1:0]      occupancy
);

  logic [DEPTH-1:0]      v_reg;
  logic [DEPTH-1:0]      v_next;
  logic [DEPTH-1:0]      load;
  logic [DEPTH-1:0]      move;
  logic [DEPTH-1:0]      stage_in_v;
  logic [DATA_WIDTH-1:0] d_reg      [DEPTH];
  logic [DATA_WIDTH-1:0] stage_in_d [DEPTH];
  logic                  src_valid;
  logic [DATA_WIDTH-1:0] src_data;
  logic                  sv_next;
  logic [OCC_W-1:0]      occ_reg;
  logic [OCC_W-1:0]      occ_next;

  // Ready ripples backwards: a stage can load if it is empty or draining this cycle.
  always_comb begin
    logic ds_ready;
    ds_ready = out_ready;
    move     = '0;
    load     = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      move[k]  = v_reg[k] && ds_ready;
      load[k]  = !v_reg[k] || move[k];
      ds_ready = load[k];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign stage_in_v[gi] = src_valid;
        assign stage_in_d[gi] = src_data;
      end else begin : g_body
        assign stage_in_v[gi] = v_reg[gi-1];
        assign stage_in_d[gi] = d_reg[gi-1];
      end

      assign v_next[gi] = flush ? 1'b0 : (load[gi] ? stage_in_v[gi] : v_reg[gi]);

      // Data only moves with a valid payload; flushed entries leave stale data behind.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          d_reg[gi] <= '0;
        end else if (!flush && load[gi] && stage_in_v[gi]) begin
          d_reg[gi] <= stage_in_d[gi];
        end
      end
    end

    if (SKID != 0) begin : g_skid
      logic                  sv_reg;
      logic [DATA_WIDTH-1:0] sd_reg;
      logic                  in_fire;

      assign in_ready  = !sv_reg;
      assign in_fire   = in_valid && in_ready;
      assign src_valid = sv_reg || in_fire;
      assign src_data  = sv_reg ? sd_reg : in_data;
      assign sv_next   = flush ? 1'b0 : (sv_reg ? !load[0] : (in_fire && !load[0]));

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sv_reg <= 1'b0;
          sd_reg <= '0;
        end else begin
          sv_reg <= sv_next;
          if (!flush && in_fire && !load[0]) begin
            sd_reg <= in_data;
          end
        end
      end
    end else begin : g_no_skid
      assign in_ready  = load[0];
      assign src_valid = in_valid;
      assign src_data  = in_data;
      assign sv_next   = 1'b0;
    end
  endgenerate

  always_comb begin
    occ_next = OCC_W'(sv_next);
    for (int k = 0; k < DEPTH; k++) begin
      occ_next = occ_next + OCC_W'(v_next[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_reg   <= '0;
      occ_reg <= '0;
    end else begin
      v_reg   <= v_next;
      occ_reg <= occ_next;
    end
  end

  assign out_valid = v_reg[DEPTH-1];
  assign out_data  = d_reg[DEPTH-1];
  assign occupancy = occ_reg;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: four instances (D3S1, D2S1, D4S1, D1S0)
// exercised one at a time with hand-computed expectations.
module tb_pipe_stage_elastic;

  logic clk;
  logic rst_n;

  logic       a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0] a_in_data, a_out_data;
  logic [2:0] a_occ;
  logic       b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0] b_in_data, b_out_data;
  logic [1:0] b_occ;
  logic       c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [7:0] c_in_data, c_out_data;
  logic [2:0] c_occ;
  logic       z_flush, z_in_valid, z_in_ready, z_out_valid, z_out_ready;
  logic [7:0] z_in_data, z_out_data;
  logic [0:0] z_occ;

  int checks;
  int failures;

  pipe_stage_elastic #(.DATA_WIDTH(8), .DEPTH(3), .SKID(1)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .occupancy(a_occ)
  );
  pipe_stage_elastic #(.DATA_WIDTH(8), .DEPTH(2), .SKID(1)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .occupancy(b_occ)
  );
  pipe_stage_elastic #(.DATA_WIDTH(8), .DEPTH(4), .SKID(1)) u_c (
    .clk(clk), .rst_n(rst_n), .flush(c_flush),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .occupancy(c_occ)
  );
  pipe_stage_elastic #(.DATA_WIDTH(8), .DEPTH(1), .SKID(0)) u_z (
    .clk(clk), .rst_n(rst_n), .flush(z_flush),
    .in_valid(z_in_valid), .in_ready(z_in_ready), .in_data(z_in_data),
    .out_valid(z_out_valid), .out_ready(z_out_ready), .out_data(z_out_data),
    .occupancy(z_occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One line per delivered payload.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_out_valid && a_out_ready) $display("a out 0x%02h", a_out_data);
      if (b_out_valid && b_out_ready) $display("b out 0x%02h", b_out_data);
      if (c_out_valid && c_out_ready) $display("c out 0x%02h", c_out_data);
      if (z_out_valid && z_out_ready) $display("z out 0x%02h", z_out_data);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted;
    int idx;
    logic acc;
    logic [7:0] exp_rdy;
    logic [7:0] exp_ov;
    logic [7:0] exp_od [8];

    checks   = 0;
    failures = 0;
    rst_n = 1'b0;
    a_flush = 0; a_in_valid = 0; a_in_data = 0; a_out_ready = 0;
    b_flush = 0; b_in_valid = 1; b_in_data = 8'h77; b_out_ready = 1;
    c_flush = 0; c_in_valid = 0; c_in_data = 0; c_out_ready = 0;
    z_flush = 0; z_in_valid = 0; z_in_data = 0; z_out_ready = 0;

    // Reset held for 2 cycles with in_valid asserted.
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("rst_b_out_valid", 32'(b_out_valid), 32'd0);
      check_eq("rst_b_out_data", 32'(b_out_data), 32'd0);
      check_eq("rst_b_occ", 32'(b_occ), 32'd0);
    end
    check_eq("rst_b_in_ready", 32'(b_in_ready), 32'd1);
    check_eq("rst_z_in_ready", 32'(z_in_ready), 32'd1);
    check_eq("rst_z_occ", 32'(z_occ), 32'd0);
    rst_n = 1'b1;
    step();
    b_in_valid = 0;
    check_eq("rst_first_lat0", 32'(b_out_valid), 32'd0);
    step();
    check_eq("rst_first_valid", 32'(b_out_valid), 32'd1);
    check_eq("rst_first_data", 32'(b_out_data), 32'h77);
    step();
    check_eq("rst_first_drained", 32'(b_out_valid), 32'd0);
    check_eq("rst_first_occ", 32'(b_occ), 32'd0);
    b_out_ready = 0;

    // Streaming on DEPTH=3: item accepted at edge n is visible after edge n+2.
    a_out_ready = 1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      a_in_valid = (cyc < 16);
      a_in_data  = 8'(8'h10 + cyc);
      check_eq("stream_in_ready", 32'(a_in_ready), 32'd1);
      step();
      if (cyc >= 2 && cyc < 18) begin
        check_eq("stream_out_valid", 32'(a_out_valid), 32'd1);
        check_eq("stream_out_data", 32'(a_out_data), 32'(8'h10 + cyc - 2));
      end else begin
        check_eq("stream_out_idle", 32'(a_out_valid), 32'd0);
      end
    end
    a_in_valid = 0;
    check_eq("stream_occ_end", 32'(a_occ), 32'd0);

    // Full stall on DEPTH=2 SKID=1: exactly 3 payloads accepted.
    idx = 0;
    accepted = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      b_in_valid = (idx < 4);
      b_in_data  = 8'(8'hA1 + idx);
      acc = b_in_valid && b_in_ready;
      step();
      if (acc) begin
        idx++;
        accepted++;
      end
    end
    check_eq("stall_accepted", 32'(accepted), 32'd3);
    check_eq("stall_in_ready", 32'(b_in_ready), 32'd0);
    check_eq("stall_occ", 32'(b_occ), 32'd3);
    b_out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      check_eq("stall_out_valid", 32'(b_out_valid), 32'd1);
      check_eq("stall_out_data", 32'(b_out_data), 32'(8'hA1 + k));
      b_in_valid = (idx < 4);
      b_in_data  = 8'(8'hA1 + idx);
      acc = b_in_valid && b_in_ready;
      step();
      if (acc) idx++;
      if (k == 0) check_eq("stall_ready_rise", 32'(b_in_ready), 32'd1);
    end
    b_in_valid = 0;
    check_eq("stall_all_offered", 32'(idx), 32'd4);
    check_eq("stall_drained", 32'(b_out_valid), 32'd0);
    b_out_ready = 0;

    // Bubble collapse on DEPTH=4: two payloads two cycles apart pack together.
    c_in_valid = 1; c_in_data = 8'h01;
    step();
    c_in_valid = 0;
    step();
    c_in_valid = 1; c_in_data = 8'h02;
    step();
    c_in_valid = 0;
    for (int i = 0; i < 4; i++) step();
    check_eq("bubble_occ", 32'(c_occ), 32'd2);
    check_eq("bubble_head_valid", 32'(c_out_valid), 32'd1);
    check_eq("bubble_head_data", 32'(c_out_data), 32'h01);
    c_out_ready = 1;
    step();
    check_eq("bubble_second_valid", 32'(c_out_valid), 32'd1);
    check_eq("bubble_second_data", 32'(c_out_data), 32'h02);
    step();
    check_eq("bubble_drained", 32'(c_out_valid), 32'd0);

    // Flush on DEPTH=2 full with a pending input.
    b_in_valid = 1; b_in_data = 8'hB1;
    step();
    b_in_data = 8'hB2;
    step();
    check_eq("flush_pre_occ", 32'(b_occ), 32'd2);
    b_in_data = 8'hB3; b_flush = 1; b_out_ready = 1;
    check_eq("flush_head_valid", 32'(b_out_valid), 32'd1);
    check_eq("flush_head_data", 32'(b_out_data), 32'hB1);
    step();
    b_flush = 0; b_in_valid = 0;
    check_eq("flush_occ", 32'(b_occ), 32'd0);
    check_eq("flush_in_ready", 32'(b_in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check_eq("flush_no_output", 32'(b_out_valid), 32'd0);
      step();
    end

    // SKID=0 DEPTH=1 with out_ready toggling 1010 and in_valid held high.
    exp_rdy = 8'b0101_0101;
    exp_ov  = 8'b1111_1110;
    exp_od  = '{8'h00, 8'h30, 8'h30, 8'h31, 8'h31, 8'h32, 8'h32, 8'h33};
    idx = 0;
    z_in_valid = 1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      z_out_ready = (cyc % 2 == 0);
      z_in_data   = 8'(8'h30 + idx);
      #1;
      check_eq("noskid_in_ready", 32'(z_in_ready), 32'(exp_rdy[cyc]));
      check_eq("noskid_out_valid", 32'(z_out_valid), 32'(exp_ov[cyc]));
      if (exp_ov[cyc]) check_eq("noskid_out_data", 32'(z_out_data), 32'(exp_od[cyc]));
      acc = z_in_valid && z_in_ready;
      step();
      if (acc) idx++;
    end
    z_in_valid = 0;
    check_eq("noskid_accepted", 32'(idx), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
